// File: rtl/mem_dma_pkg.sv
// Shared definitions for the memory DMA engine: FSM state encoding,
// transfer mode encoding, word stride and a range-check helper.
package mem_dma_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    // Byte distance between consecutive RAM words.
    localparam int unsigned WORD_STRIDE = 32'd4;

    // True when a block of len words starting at word index base_word
    // stays inside a RAM of mem_words words. Operands are widened by the
    // caller so the sum cannot wrap.
    function automatic logic range_ok(input logic [63:0] base_word,
                                      input logic [63:0] len_words,
                                      input logic [63:0] mem_words);
        return (base_word + len_words) <= mem_words;
    endfunction

endpackage

// File: rtl/mem_dma_addr_gen.sv
// Pointer / count datapath for the DMA engine.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   load         : accept a validated command (len >= 1)
//   step         : one word has been written; advance pointers, count down
//   copy_mode    : 1 for copy (direction may be descending), 0 for fill
//   src_in/dst_in/len_in : command fields sampled on load
//   src_nxt/dst_nxt : pointer values that will be held after this edge
//   last         : the word currently being written is the final one
module mem_dma_addr_gen
    import mem_dma_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic              copy_mode,
    input  logic [ADDR_W-1:0] src_in,
    input  logic [ADDR_W-1:0] dst_in,
    input  logic [LEN_W-1:0]  len_in,
    output logic [ADDR_W-1:0] src_nxt,
    output logic [ADDR_W-1:0] dst_nxt,
    output logic              last
);

    localparam int WIDE = ADDR_W + LEN_W + 3;
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WORD_STRIDE);

    logic [ADDR_W-1:0] src_ptr_r;
    logic [ADDR_W-1:0] dst_ptr_r;
    logic [LEN_W-1:0]  cnt_r;
    logic              desc_r;

    logic [LEN_W-1:0]  cnt_nxt_s;
    logic              desc_nxt_s;
    logic [WIDE-1:0]   src_w_s;
    logic [WIDE-1:0]   dst_w_s;
    logic [WIDE-1:0]   src_end_w_s;
    logic              overlap_s;
    logic [ADDR_W-1:0] tail_off_s;

    // Overlap test in widened arithmetic: a copy whose destination starts
    // inside the source block must run top-down so unread source words are
    // not overwritten first.
    assign src_w_s     = WIDE'(src_in);
    assign dst_w_s     = WIDE'(dst_in);
    assign src_end_w_s = src_w_s + (WIDE'(len_in) << 2);
    assign overlap_s   = copy_mode && (dst_w_s > src_w_s) && (dst_w_s < src_end_w_s);
    assign tail_off_s  = ADDR_W'(len_in - LEN_W'(1)) << 2;

    assign last = (cnt_r == LEN_W'(1));

    // Next pointer/count values: load initial pointers, step, or hold.
    always_comb begin
        src_nxt    = src_ptr_r;
        dst_nxt    = dst_ptr_r;
        cnt_nxt_s  = cnt_r;
        desc_nxt_s = desc_r;
        if (load) begin
            desc_nxt_s = overlap_s;
            cnt_nxt_s  = len_in;
            if (overlap_s) begin
                src_nxt = src_in + tail_off_s;
                dst_nxt = dst_in + tail_off_s;
            end else begin
                src_nxt = src_in;
                dst_nxt = dst_in;
            end
        end else if (step) begin
            cnt_nxt_s = cnt_r - LEN_W'(1);
            if (desc_r) begin
                src_nxt = src_ptr_r - STRIDE;
                dst_nxt = dst_ptr_r - STRIDE;
            end else begin
                src_nxt = src_ptr_r + STRIDE;
                dst_nxt = dst_ptr_r + STRIDE;
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Pointer, count and direction registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_ptr_r <= '0;
            dst_ptr_r <= '0;
            cnt_r     <= '0;
            desc_r    <= 1'b0;
        end else begin
            src_ptr_r <= src_nxt;
            dst_ptr_r <= dst_nxt;
            cnt_r     <= cnt_nxt_s;
            desc_r    <= desc_nxt_s;
        end
    end

endmodule

// File: rtl/mem_dma_engine.sv
// Memory DMA engine: block copy (RAM to RAM) and block fill (pattern to
// RAM) through the single data-RAM port, which it owns while busy.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start, mode     : command strobe (sampled in IDLE), 0 = copy, 1 = fill
//   src_addr, dst_addr, len, fill_data : command fields
//   busy, done, err : status; done/err are one-cycle pulses
//   mem_we, mem_a, mem_wd : RAM write enable, byte address, write data
//   mem_rd          : combinational RAM read data for mem_a
// All outputs are registered; they are computed from next-state values so
// their timing matches a Moore decode of the current state.
module mem_dma_engine
    import mem_dma_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 12,
    parameter int MEM_WORDS = 102
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] fill_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    state_t            state_r;
    state_t            state_nxt_s;
    logic              mode_r;
    logic              mode_nxt_s;
    logic [DATA_W-1:0] fill_r;
    logic [DATA_W-1:0] fill_nxt_s;
    logic [DATA_W-1:0] data_r;
    logic [DATA_W-1:0] data_nxt_s;
    logic              err_pend_r;
    logic              err_pend_nxt_s;
    logic              load_s;
    logic              step_s;
    logic              last_s;
    logic [ADDR_W-1:0] src_nxt_s;
    logic [ADDR_W-1:0] dst_nxt_s;

    logic              aligned_s;
    logic              dst_fit_s;
    logic              src_fit_s;
    logic              cmd_ok_s;

    logic              busy_nxt_s;
    logic              done_nxt_s;
    logic              we_nxt_s;
    logic [ADDR_W-1:0] a_nxt_s;
    logic [DATA_W-1:0] wd_nxt_s;

    // Command validation on the live inputs, done in the accepting cycle.
    assign aligned_s = (src_addr[1:0] == 2'b00) && (dst_addr[1:0] == 2'b00);
    assign dst_fit_s = range_ok(64'(dst_addr >> 2), 64'(len), 64'(MEM_WORDS));
    assign src_fit_s = range_ok(64'(src_addr >> 2), 64'(len), 64'(MEM_WORDS));
    assign cmd_ok_s  = aligned_s && dst_fit_s && ((mode == MODE_FILL) || src_fit_s);

    mem_dma_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .step      (step_s),
        .copy_mode (mode == MODE_COPY),
        .src_in    (src_addr),
        .dst_in    (dst_addr),
        .len_in    (len),
        .src_nxt   (src_nxt_s),
        .dst_nxt   (dst_nxt_s),
        .last      (last_s)
    );

    // Next-state logic and per-state datapath controls.
    always_comb begin
        state_nxt_s    = state_r;
        mode_nxt_s     = mode_r;
        fill_nxt_s     = fill_r;
        data_nxt_s     = data_r;
        err_pend_nxt_s = err_pend_r;
        load_s         = 1'b0;
        step_s         = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    mode_nxt_s = mode;
                    fill_nxt_s = fill_data;
                    if (!cmd_ok_s) begin
                        err_pend_nxt_s = 1'b1;
                        state_nxt_s    = DONE;
                    end else if (len == LEN_W'(0)) begin
                        err_pend_nxt_s = 1'b0;
                        state_nxt_s    = DONE;
                    end else begin
                        err_pend_nxt_s = 1'b0;
                        load_s         = 1'b1;
                        state_nxt_s    = (mode == MODE_FILL) ? WR : RD;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RD: begin
                data_nxt_s  = mem_rd;
                state_nxt_s = WR;
            end
            WR: begin
                step_s = 1'b1;
                if (last_s) begin
                    state_nxt_s = DONE;
                end else if (mode_r == MODE_COPY) begin
                    state_nxt_s = RD;
                end else begin
                    state_nxt_s = WR;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, decoded from the next state.
    always_comb begin
        busy_nxt_s = (state_nxt_s == RD) || (state_nxt_s == WR);
        done_nxt_s = (state_nxt_s == DONE);
        we_nxt_s   = (state_nxt_s == WR);
        a_nxt_s    = '0;
        wd_nxt_s   = '0;
        case (state_nxt_s)
            RD: begin
                a_nxt_s = src_nxt_s;
            end
            WR: begin
                a_nxt_s  = dst_nxt_s;
                wd_nxt_s = (mode_nxt_s == MODE_FILL) ? fill_nxt_s : data_nxt_s;
            end
            default: begin
                a_nxt_s  = '0;
                wd_nxt_s = '0;
            end
        endcase
    end

    // State, command latches and registered RAM-port / status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            mode_r     <= MODE_COPY;
            fill_r     <= '0;
            data_r     <= '0;
            err_pend_r <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            mem_we     <= 1'b0;
            mem_a      <= '0;
            mem_wd     <= '0;
        end else begin
            state_r    <= state_nxt_s;
            mode_r     <= mode_nxt_s;
            fill_r     <= fill_nxt_s;
            data_r     <= data_nxt_s;
            err_pend_r <= err_pend_nxt_s;
            busy       <= busy_nxt_s;
            done       <= done_nxt_s;
            err        <= done_nxt_s && err_pend_nxt_s;
            mem_we     <= we_nxt_s;
            mem_a      <= a_nxt_s;
            mem_wd     <= wd_nxt_s;
        end
    end

endmodule

// File: tb/tb_mem_dma_engine.sv
// Scoreboard bench for mem_dma_engine: a memmove-style reference model
// pushes expected writes and completions; a negedge monitor checks them.
module tb_mem_dma_engine;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int LEN_W     = 12;
    localparam int MEM_WORDS = 102;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              mode;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] fill_data;
    logic              busy;
    logic              done;
    logic              err;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem_rd;

    mem_dma_engine #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .LEN_W     (LEN_W),
        .MEM_WORDS (MEM_WORDS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .fill_data (fill_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_we    (mem_we),
        .mem_a     (mem_a),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd)
    );

    always #5 clk = ~clk;

    // RAM behind the port, plus the initial image and the reference image.
    logic [31:0] ram       [0:4095];
    logic [31:0] seed_mem  [0:4095];
    logic [31:0] model_mem [0:4095];
    logic        ram_load;

    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 4096; i++) ram[i] <= seed_mem[i];
        end else if (mem_we) begin
            ram[mem_a[13:2]] <= mem_wd;
        end
    end
    assign mem_rd = ram[mem_a[13:2]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct { int start; int lat; logic err; } dn_t;
    wr_t exp_wr[$];
    dn_t exp_dn[$];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int image_diff();
        int bad = 0;
        for (int i = 0; i < 128; i++) if (ram[i] !== model_mem[i]) bad++;
        return bad;
    endfunction

    // Monitor: compare every write and every completion against the queues.
    always @(negedge clk) begin
        wr_t w;
        dn_t d;
        if (!rst && !ram_load) begin
            if (mem_we) begin
                if (exp_wr.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", mem_a, mem_wd);
                end else begin
                    w = exp_wr.pop_front();
                    check("write_addr", 64'(mem_a), 64'(w.addr));
                    check("write_data", 64'(mem_wd), 64'(w.data));
                    check("busy_in_write", 64'(busy), 64'd1);
                end
            end
            if (done) begin
                if (exp_dn.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_done: err=%0d at cycle %0d", err, cyc);
                end else begin
                    d = exp_dn.pop_front();
                    check("done_latency", 64'(cyc - d.start), 64'(d.lat));
                    check("err_flag", 64'(err), 64'(d.err));
                    check("busy_at_done", 64'(busy), 64'd0);
                    check("writes_left", 64'(exp_wr.size()), 64'd0);
                    check("ram_image", 64'(image_diff()), 64'd0);
                end
            end else if (err) begin
                n_cmp++; n_fail++;
                $display("FAIL err_without_done: err=1 done=0 at cycle %0d", cyc);
            end
        end
    end

    // Issue one command and push its expected effects. limit >= 0 means the
    // transfer will be cut short by reset after that many writes.
    task automatic issue(input logic m, input logic [31:0] s, input logic [31:0] d,
                         input logic [11:0] n, input logic [31:0] f, input int limit);
        logic        ok;
        logic        desc;
        int          lat;
        logic        e;
        int          nw;
        int          idx;
        logic [31:0] vals[$];
        dn_t         dn;
        wr_t         w;
        mode = m; src_addr = s; dst_addr = d; len = n; fill_data = f; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mode = 1'($urandom); src_addr = $urandom; dst_addr = $urandom;
        len = 12'($urandom); fill_data = $urandom;

        ok = (s % 4 == 0) && (d % 4 == 0) && (longint'(d / 4) + longint'(n) <= MEM_WORDS)
             && (m || (longint'(s / 4) + longint'(n) <= MEM_WORDS));
        if (!ok) begin
            lat = 1; e = 1'b1; nw = 0;
        end else if (n == 0) begin
            lat = 1; e = 1'b0; nw = 0;
        end else begin
            e = 1'b0; nw = int'(n);
            lat = m ? nw + 1 : 2 * nw + 1;
        end
        for (int i = 0; i < nw; i++) vals.push_back(m ? f : model_mem[s / 4 + i]);
        desc = !m && (d > s) && (longint'(d) < longint'(s) + 4 * longint'(n));
        for (int k = 0; k < nw; k++) begin
            idx = desc ? nw - 1 - k : k;
            if (limit < 0 || k < limit) begin
                w.addr = d + 32'(4 * idx);
                w.data = vals[idx];
                exp_wr.push_back(w);
                model_mem[d / 4 + idx] = vals[idx];
            end
        end
        if (limit < 0) begin
            dn.start = cyc - 1; dn.lat = lat; dn.err = e;
            exp_dn.push_back(dn);
        end
    endtask

    // Wait (bounded) for done, then step into the following IDLE cycle.
    task automatic wait_done();
        logic seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++; n_fail++;
            $display("FAIL done_timeout: no done within 400 cycles");
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic        m;
        int          dw;
        int          sw;
        logic [11:0] n;
        logic [31:0] s;
        logic [31:0] d;
        rst = 1'b1; ram_load = 1'b1; start = 1'b0; mode = 1'b0;
        src_addr = '0; dst_addr = '0; len = '0; fill_data = '0;
        for (int i = 0; i < 4096; i++) begin
            seed_mem[i]  = (i < 128) ? $urandom : 32'd0;
            model_mem[i] = seed_mem[i];
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; ram_load = 1'b0;
        check("reset_ctrl", 64'({busy, done, err, mem_we}), 64'd0);
        check("reset_mem_a", 64'(mem_a), 64'd0);
        check("reset_mem_wd", 64'(mem_wd), 64'd0);

        // Directed cases.
        issue(1'b0, 32'h00, 32'h40, 12'd3, 32'd0, -1);          wait_done();
        issue(1'b0, 32'h00, 32'h04, 12'd3, 32'd0, -1);          wait_done();
        issue(1'b1, 32'h00, 32'h80, 12'd4, 32'hDEADBEEF, -1);   wait_done();
        issue(1'b0, 32'h00, 32'h40, 12'd0, 32'd0, -1);          wait_done();
        issue(1'b0, 32'h02, 32'h40, 12'd2, 32'd0, -1);          wait_done();
        issue(1'b0, 32'h00, 32'h190, 12'd3, 32'd0, -1);         wait_done();

        // Reset in cycle 3 of a 4-word copy: only the first word lands.
        issue(1'b0, 32'h00, 32'h100, 12'd4, 32'd0, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_we", 64'(mem_we), 64'd0);
        repeat (3) begin @(posedge clk); #1; end
        check("abort_writes_left", 64'(exp_wr.size()), 64'd0);
        check("abort_image", 64'(image_diff()), 64'd0);

        // Start pulsed during cycle 2 of a transfer is ignored.
        issue(1'b0, 32'h20, 32'h60, 12'd4, 32'd0, -1);
        @(posedge clk); #1;
        start = 1'b1; mode = 1'b1; dst_addr = 32'h0; len = 12'd5; fill_data = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();

        // Back-to-back: second start in the cycle right after done.
        issue(1'b0, 32'h40, 32'h120, 12'd2, 32'd0, -1);         wait_done();
        issue(1'b1, 32'h10, 32'h10, 12'd3, $urandom, -1);       wait_done();

        // Randomized commands, gaps of 0..2 idle cycles.
        for (int t = 0; t < 60; t++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            m  = 1'($urandom_range(0, 1));
            dw = int'($urandom_range(0, 105));
            sw = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 105))
                                             : dw + int'($urandom_range(0, 6)) - 3;
            if (sw < 0) sw = 0;
            n  = ($urandom_range(0, 9) < 8) ? 12'($urandom_range(0, 12)) : 12'($urandom_range(0, 120));
            s  = 32'(sw * 4);
            d  = 32'(dw * 4);
            if ($urandom_range(0, 9) == 0) s = s + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) d = d + 32'($urandom_range(1, 3));
            issue(m, s, d, n, $urandom, -1);
            wait_done();
        end

        repeat (3) begin @(posedge clk); #1; end
        check("pending_done", 64'(exp_dn.size()), 64'd0);
        check("pending_writes", 64'(exp_wr.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
